ef_gpion_apb: RTL and testbench

//  Parametrised W-pin GPIO with APB slave: per-pin direction, atomic set/clear of outputs,
//  2-flop input sync, optional per-pin debounce, per-pin rising/falling edge interrupts.

---
 rtl/ef_gpion_apb.sv | 155 +++++++++++++++
 tb/tb_ef_gpion_apb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ef_gpion_apb.sv
// ef_gpion_apb: W-pin GPIO behind an APB slave. It provides per-pin direction,
// atomic set/clear of the output data, a 2-flop input synchroniser, optional
// per-pin debounce, and rising/falling edge interrupts.
module ef_gpion_apb #(
    parameter int unsigned W      = 8,
    parameter int unsigned DB_LEN = 4
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    input  logic [15:0]  PADDR,
    input  logic         PSEL,
    input  logic         PENABLE,
    input  logic         PWRITE,
    input  logic [31:0]  PWDATA,
    output logic [31:0]  PRDATA,
    output logic         PREADY,
    output logic         IRQ,
    input  logic [W-1:0] io_in,
    output logic [W-1:0] io_out,
    output logic [W-1:0] io_oe
);

    localparam int unsigned CW = 4;
    localparam int unsigned AW = 14;
    localparam int unsigned PW = 16;

    localparam logic [AW-1:0] A_DATAI = 14'h000;
    localparam logic [AW-1:0] A_DATAO = 14'h001;
    localparam logic [AW-1:0] A_DIR   = 14'h002;
    localparam logic [AW-1:0] A_SET   = 14'h003;
    localparam logic [AW-1:0] A_CLR   = 14'h004;
    localparam logic [AW-1:0] A_DBEN  = 14'h005;
    localparam logic [AW-1:0] A_DBPRE = 14'h006;
    localparam logic [AW-1:0] A_IM    = 14'h3C0;
    localparam logic [AW-1:0] A_MIS   = 14'h3C1;
    localparam logic [AW-1:0] A_RIS   = 14'h3C2;
    localparam logic [AW-1:0] A_IC    = 14'h3C3;

    logic [AW-1:0]  addr;
    logic           wr_en;
    logic [W-1:0]   datao, dir, dben;
    logic [PW-1:0]  dbpre, pre_cnt;
    logic           tick;
    logic [W-1:0]   s1, s2, filt_reg, filt, prev, rise, fall;
    logic [CW-1:0]  cnt [W];
    logic [2*W-1:0] im, ris, ic;
    logic           unused_bits;

    assign addr        = PADDR[15:2];
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    assign PREADY = 1'b1;
    assign io_out = datao;
    assign io_oe  = dir;
    assign IRQ    = |(ris & im);

    // Software-visible control registers; writes commit in the access phase only
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            datao <= '0;
            dir   <= '0;
            dben  <= '0;
            dbpre <= '0;
            im    <= '0;
        end else if (wr_en) begin
            case (addr)
                A_DATAO: datao <= PWDATA[W-1:0];
                A_DIR:   dir   <= PWDATA[W-1:0];
                A_SET:   datao <= datao | PWDATA[W-1:0];
                A_CLR:   datao <= datao & ~PWDATA[W-1:0];
                A_DBEN:  dben  <= PWDATA[W-1:0];
                A_DBPRE: dbpre <= PWDATA[PW-1:0];
                A_IM:    im    <= PWDATA[2*W-1:0];
                default: ;
            endcase
        end
    end

    // Debounce prescaler; >= keeps it bounded if DBPRE is lowered mid-count
    assign tick = (pre_cnt >= dbpre);

    always_ff @(posedge PCLK) begin
        if (!PRESETn || tick) pre_cnt <= '0;
        else                  pre_cnt <= PW'(pre_cnt + PW'(1));
    end

    // Two-flop synchroniser for the asynchronous pads
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= io_in;
            s2 <= s1;
        end
    end

    // Per-pin debounce: accept a new level after DB_LEN consecutive differing ticks
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < int'(W); i++) begin
            if (!PRESETn) begin
                cnt[i]      <= '0;
                filt_reg[i] <= 1'b0;
            end else if (!dben[i]) begin
                cnt[i]      <= '0;
                filt_reg[i] <= s2[i];
            end else if (tick) begin
                if (s2[i] != filt_reg[i]) begin
                    if (cnt[i] == CW'(DB_LEN - 1)) begin
                        filt_reg[i] <= s2[i];
                        cnt[i]      <= '0;
                    end else begin
                        cnt[i] <= CW'(cnt[i] + CW'(1));
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign filt = (dben & filt_reg) | (~dben & s2);
    assign rise = filt & ~prev;
    assign fall = ~filt & prev;
    assign ic   = (wr_en && addr == A_IC) ? PWDATA[2*W-1:0] : '0;

    // Edge history and sticky raw interrupt status; a new edge beats a same-cycle clear
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            prev <= '0;
            ris  <= '0;
        end else begin
            prev <= filt;
            ris  <= (ris & ~ic) | {fall, rise};
        end
    end

    // Read mux straight from the registers
    always_comb begin
        PRDATA = '0;
        case (addr)
            A_DATAI: PRDATA = 32'(filt);
            A_DATAO: PRDATA = 32'(datao);
            A_DIR:   PRDATA = 32'(dir);
            A_DBEN:  PRDATA = 32'(dben);
            A_DBPRE: PRDATA = 32'(dbpre);
            A_IM:    PRDATA = 32'(im);
            A_MIS:   PRDATA = 32'(ris & im);
            A_RIS:   PRDATA = 32'(ris);
            default: PRDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_ef_gpion_apb.sv
// Bench for ef_gpion_apb: an 8-pin instance for most scenarios and a 16-pin
// instance for the wide interrupt case, both on one shared APB bus.
module tb_ef_gpion_apb;

    localparam logic [15:0] A_DATAI = 16'h0000;
    localparam logic [15:0] A_DATAO = 16'h0004;
    localparam logic [15:0] A_DIR   = 16'h0008;
    localparam logic [15:0] A_SET   = 16'h000C;
    localparam logic [15:0] A_CLR   = 16'h0010;
    localparam logic [15:0] A_DBEN  = 16'h0014;
    localparam logic [15:0] A_DBPRE = 16'h0018;
    localparam logic [15:0] A_IM    = 16'h0F00;
    localparam logic [15:0] A_MIS   = 16'h0F04;
    localparam logic [15:0] A_RIS   = 16'h0F08;
    localparam logic [15:0] A_IC    = 16'h0F0C;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [15:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] prdata8, prdata16;
    logic        pready8, pready16, irq8, irq16;
    logic [7:0]  io_in8, io_out8, io_oe8;
    logic [15:0] io_in16, io_out16, io_oe16;

    int n_chk  = 0;
    int n_pass = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 PCLK = ~PCLK;

    ef_gpion_apb #(.W(8), .DB_LEN(4)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata8),
        .PREADY(pready8), .IRQ(irq8), .io_in(io_in8), .io_out(io_out8), .io_oe(io_oe8)
    );

    ef_gpion_apb #(.W(16), .DB_LEN(4)) u_dut16 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata16),
        .PREADY(pready16), .IRQ(irq16), .io_in(io_in16), .io_out(io_out16), .io_oe(io_oe16)
    );

    // Single comparison point
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check_eq(t, got, e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
        sb_push(tag, exp);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 sb_pop(prdata8);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Cycle-accurate look at a register through the combinational read path
    task automatic peek(input logic [15:0] a, input logic [31:0] exp, input string tag, input bit wide);
        sb_push(tag, exp);
        PADDR = a;
        #1;
        if (wide) sb_pop(prdata16);
        else      sb_pop(prdata8);
    endtask

    task automatic pin(input string tag, input logic [31:0] got, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_pop(got);
    endtask

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; io_in8 = '0; io_in16 = '0;
        cyc(3);
        pin("rst_io_out", 32'(io_out8), 32'h0);
        pin("rst_io_oe", 32'(io_oe8), 32'h0);
        pin("rst_irq", 32'(irq8), 32'h0);
        pin("pready", 32'(pready8), 32'h1);
        peek(A_DATAI, 32'h0, "rst_datai", 1'b0);
        peek(A_RIS, 32'h0, "rst_ris", 1'b0);
        PRESETn = 1'b1;
        cyc(1);

        // Direction, output data and atomic set/clear
        apb_write(A_DIR, 32'hFF);
        apb_write(A_DATAO, 32'hA5);
        pin("oe_ff", 32'(io_oe8), 32'hFF);
        pin("out_a5", 32'(io_out8), 32'hA5);
        apb_write(A_SET, 32'h0A);
        pin("out_set", 32'(io_out8), 32'hAF);
        apb_read(A_DATAO, 32'hAF, "rd_datao_af");
        apb_write(A_CLR, 32'h81);
        pin("out_clr", 32'(io_out8), 32'h2E);
        apb_read(A_SET, 32'h0, "rd_set_zero");
        apb_read(A_CLR, 32'h0, "rd_clr_zero");
        apb_write(16'h0020, 32'hFFFF_FFFF);
        apb_read(A_DATAO, 32'h2E, "unmapped_wr_ignored");
        peek(16'h0100, 32'h0, "unmapped_rd", 1'b0);
        peek(A_DIR, 32'hFF, "dir_kept", 1'b0);

        // Input sync latency, then reset with pins held high
        apb_write(A_DIR, 32'h0);
        pin("oe_off", 32'(io_oe8), 32'h0);
        io_in8 = 8'hAB;
        cyc(1);
        peek(A_DATAI, 32'h0, "datai_k", 1'b0);
        cyc(1);
        peek(A_DATAI, 32'hAB, "datai_k1", 1'b0);
        PRESETn = 1'b0;
        cyc(1);
        peek(A_DATAI, 32'h0, "rst_datai_mid", 1'b0);
        pin("rst_out_mid", 32'(io_out8), 32'h0);
        pin("rst_irq_mid", 32'(irq8), 32'h0);
        cyc(1);
        PRESETn = 1'b1;
        cyc(2);
        peek(A_RIS, 32'h0, "ris_rel2", 1'b0);
        cyc(1);
        peek(A_RIS, 32'hAB, "ris_rel3", 1'b0);

        // Rising/falling interrupt on pin 0 with mask
        io_in8 = 8'h00;
        cyc(4);
        apb_write(A_IC, 32'hFFFF);
        peek(A_RIS, 32'h0, "ic_all", 1'b0);
        apb_write(A_IM, 32'h0001);
        io_in8 = 8'h01;
        cyc(1);
        peek(A_DATAI, 32'h0, "p0_datai_k", 1'b0);
        cyc(1);
        peek(A_DATAI, 32'h1, "p0_datai_k1", 1'b0);
        peek(A_RIS, 32'h0, "p0_ris_k1", 1'b0);
        pin("p0_irq_k1", 32'(irq8), 32'h0);
        cyc(1);
        peek(A_RIS, 32'h1, "p0_ris_k2", 1'b0);
        peek(A_MIS, 32'h1, "p0_mis_k2", 1'b0);
        pin("p0_irq_k2", 32'(irq8), 32'h1);
        apb_write(A_IC, 32'h0001);
        pin("p0_irq_clr", 32'(irq8), 32'h0);
        io_in8 = 8'h00;
        cyc(4);
        peek(A_RIS, 32'h0100, "p0_fall_ris", 1'b0);
        pin("p0_fall_irq", 32'(irq8), 32'h0);

        // Edge on pin 3 in the same cycle as its clear
        apb_write(A_IC, 32'hFFFF);
        io_in8 = 8'h08;
        cyc(1);
        apb_write(A_IC, 32'h0008);
        peek(A_RIS, 32'h0008, "set_beats_clr", 1'b0);
        io_in8 = 8'h00;
        cyc(4);
        apb_write(A_IC, 32'hFFFF);
        peek(A_RIS, 32'h0, "ic_after_p3", 1'b0);

        // Debounce: short pulse rejected, long level accepted
        apb_write(A_DBPRE, 32'd9);
        apb_write(A_DBEN, 32'h01);
        cyc(20);
        io_in8 = 8'h01;
        cyc(12);
        peek(A_DATAI, 32'h0, "db_pulse_mid", 1'b0);
        cyc(13);
        io_in8 = 8'h00;
        cyc(30);
        peek(A_DATAI, 32'h0, "db_pulse_after", 1'b0);
        peek(A_RIS, 32'h0, "db_pulse_ris", 1'b0);
        io_in8 = 8'h01;
        cyc(25);
        peek(A_DATAI, 32'h0, "db_hold_25", 1'b0);
        cyc(35);
        peek(A_DATAI, 32'h1, "db_hold_60", 1'b0);
        peek(A_RIS, 32'h1, "db_hold_ris", 1'b0);
        pin("db_hold_irq", 32'(irq8), 32'h1);
        apb_write(A_IC, 32'hFFFF);
        apb_write(A_DBEN, 32'h0);
        cyc(3);
        peek(A_RIS, 32'h0, "dben_off_no_edge", 1'b0);
        peek(A_DATAI, 32'h1, "dben_off_datai", 1'b0);

        // 16-pin build: all pins fall with only falling interrupts unmasked
        apb_write(A_DATAO, 32'hFFFF);
        apb_write(A_IM, 32'hFFFF_0000);
        pin("w16_out", 32'(io_out16), 32'hFFFF);
        io_in16 = 16'hFFFF;
        cyc(4);
        apb_write(A_IC, 32'hFFFF_FFFF);
        peek(A_RIS, 32'h0, "w16_ris_clr", 1'b1);
        pin("w16_irq_rise_masked", 32'(irq16), 32'h0);
        io_in16 = 16'h0000;
        cyc(4);
        peek(A_RIS, 32'hFFFF_0000, "w16_ris_fall", 1'b1);
        peek(A_MIS, 32'hFFFF_0000, "w16_mis_fall", 1'b1);
        pin("w16_irq", 32'(irq16), 32'h1);

        check_eq("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
